// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states, wait-state limit.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int WAIT_CYC_MAX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: extracts/extends load data and merges store data into a word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [1:0]  eff_lane;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] lane_mask;

    always_comb begin
        case (size)
            SZ_BYTE: eff_lane = lane;
            SZ_HALF: eff_lane = {lane[1], 1'b0};
            default: eff_lane = 2'b00;
        endcase
        shamt   = {eff_lane, 3'b000};
        shifted = word >> shamt;

        case (size)
            SZ_BYTE: begin
                mask    = 32'h0000_00FF;
                ld_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                mask    = 32'h0000_FFFF;
                ld_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                mask    = 32'hFFFF_FFFF;
                ld_data = word;
            end
        endcase

        // Unselected lanes keep the old word's bytes.
        lane_mask = mask << shamt;
        st_word   = (word & ~lane_mask) | ((wdata & mask) << shamt);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Word-organised data RAM behind valid/ready request/response with wait states and error checks.
// Optional DMEM_STATS_EN adds load/store/error response counters.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_errs
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid
    // never waits on ready, and payload is held stable while valid is high.

    localparam int         WC       = (WAIT_CYC > WAIT_CYC_MAX) ? WAIT_CYC_MAX : WAIT_CYC;
    localparam logic [2:0] CNT_INIT = (WC == 0) ? 3'd0 : 3'(WC - 1);
    localparam int         MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         IDX_W    = ADDR_W - 2;

    state_t            state;
    logic [2:0]        cnt;
    logic              l_write;
    logic              l_signed;
    logic [1:0]        l_size;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_write;
    logic              a_signed;
    logic [1:0]        a_size;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [IDX_W-1:0]  a_idx;
    logic              a_err;
    logic              do_access;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;
    logic [DATA_W-1:0] acc_rdata;

    assign dbg_state = state;

    // With zero wait states the access happens on the accept edge, so it uses the live inputs.
    always_comb begin
        if (state == IDLE) begin
            a_write  = req_write;
            a_signed = req_signed;
            a_size   = req_size;
            a_addr   = req_addr;
            a_wdata  = req_wdata;
        end else begin
            a_write  = l_write;
            a_signed = l_signed;
            a_size   = l_size;
            a_addr   = l_addr;
            a_wdata  = l_wdata;
        end
        a_idx     = a_addr[ADDR_W-1:2];
        a_err     = (a_size == SZ_RSVD)
                  | ((a_size == SZ_HALF) && a_addr[0])
                  | ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00))
                  | ({2'b00, a_idx} >= ADDR_W'(DEPTH));
        old_word  = mem[a_idx[MEM_AW-1:0]];
        do_access = rst_n && (((state == IDLE) && req_valid && (WC == 0))
                           || ((state == WAIT) && (cnt == 3'd0)));
        acc_rdata = (a_err || a_write) ? '0 : ld_data;
    end

    dmem_lane_align u_align (
        .word    (old_word),
        .lane    (a_addr[1:0]),
        .size    (a_size),
        .sgn     (a_signed),
        .wdata   (a_wdata),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk) begin
        if (do_access && a_write && !a_err)
            mem[a_idx[MEM_AW-1:0]] <= st_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            l_write   <= 1'b0;
            l_signed  <= 1'b0;
            l_size    <= SZ_BYTE;
            l_addr    <= '0;
            l_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_write   <= req_write;
                        l_signed  <= req_signed;
                        l_size    <= req_size;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WC == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= acc_rdata;
                            rsp_err   <= a_err;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= acc_rdata;
                        rsp_err   <= a_err;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if ((state == RESP) && rsp_ready) begin
            if (rsp_err)
                stat_errs <= stat_errs + 32'd1;
            else if (l_write)
                stat_stores <= stat_stores + 32'd1;
            else
                stat_loads <= stat_loads + 32'd1;
        end
    end
`endif

endmodule
